// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: shares the single PUnC memory port between instruction
// fetch (if_), data load/store (dm_) and the debug/loader port (dbg_).
// One access at a time: IDLE -> ISSUE -> [WAIT x MEM_LAT] -> RESP -> IDLE.
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   if_req/if_addr/if_ack         fetch read requester
//   dm_req/dm_we/dm_addr/dm_wdata/dm_ack      data load/store requester
//   dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_ack debug requester
//   rdata                         registered read data, valid with owner's ack
//   grant                         one-hot owner {dbg, dm, if}, 0 when idle
//   busy                          high whenever the FSM is not idle
//   mem_addr/mem_we/mem_wdata     memory request side
//   mem_rdata                     memory read data, valid MEM_LAT cycles after issue
//
// Build option: define PUNC_ARB_RR_EN for round-robin arbitration
// (if -> dm -> dbg -> if); otherwise fixed priority dm > if > dbg.
module punc_mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [2:0]        grant,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
    $error("punc_mem_arbiter: MEM_LAT must be in 1..7");
  end

  localparam logic [2:0] LatLoad = 3'(MEM_LAT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        req;
  logic [2:0]        win;

  assign req = {dbg_req, dm_req, if_req};

`ifdef PUNC_ARB_RR_EN
  // ptr_q names the requester with top priority: 0 = if, 1 = dm, 2 = dbg.
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    win = '0;
    case (ptr_q)
      2'd1: begin
        if (req[1])      win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      2'd2: begin
        if (req[2])      win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if (req[0])      win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase

    // Advance to the requester after the winner, only when a grant is made.
    ptr_d = ptr_q;
    if (state_q == StIdle) begin
      if (win[0])      ptr_d = 2'd1;
      else if (win[1]) ptr_d = 2'd2;
      else if (win[2]) ptr_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 2'd0;
    else      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win = '0;
    if (req[1])      win = 3'b010;
    else if (req[0]) win = 3'b001;
    else if (req[2]) win = 3'b100;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = win;
          state_d = StIssue;
          if (win[1]) begin
            we_d    = dm_we;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
          end else if (win[0]) begin
            we_d    = 1'b0;
            addr_d  = if_addr;
          end else begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StResp;
        end else begin
          cnt_d   = LatLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = mem_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from registered state so reset kills mem_we and acks at once.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == StIssue) && we_q;
  assign busy      = (state_q != StIdle);
  assign grant     = grant_q;
  assign rdata     = rdata_q;
  assign if_ack    = (state_q == StResp) && grant_q[0];
  assign dm_ack    = (state_q == StResp) && grant_q[1];
  assign dbg_ack   = (state_q == StResp) && grant_q[2];

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Self-checking bench for punc_mem_arbiter: directed table, multi-cycle
// corner sequences, then random traffic against a transaction-level model.
module tb_punc_mem_arbiter;
  localparam int unsigned LAT = 3;

`ifdef PUNC_ARB_RR_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, dbg_req, dbg_we;
  logic [15:0] if_addr, dm_addr, dm_wdata, dbg_addr, dbg_wdata;
  logic        if_ack, dm_ack, dbg_ack, busy, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  grant;

  always #5 clk = ~clk;

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack),
    .rdata(rdata), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory environment: data is only presented exactly LAT cycles after issue.
  logic [15:0] mem [256];
  logic [15:0] mm  [256];
  logic        busy_d = 1'b0;
  int          lat_cnt = 0;

  function automatic logic [7:0] hidx(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[hidx(mem_addr)] = mem_wdata;
    busy_d <= busy;
    if (!busy)       lat_cnt <= 0;
    else if (!busy_d) lat_cnt <= 1;
    else             lat_cnt <= lat_cnt + 1;
  end

  assign mem_rdata = (lat_cnt == int'(LAT)) ? mem[hidx(mem_addr)] : 16'hDEAD;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int who, input logic r, input logic we, input logic [15:0] a,
                         input logic [15:0] wd);
    case (who)
      0: begin if_req = r; if_addr = a; end
      1: begin dm_req = r; dm_we = we; dm_addr = a; dm_wdata = wd; end
      default: begin dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
    endcase
  endtask

  task automatic clear_inputs();
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(2, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int pick(input logic [2:0] r, input int ptr);
    int order[3];
    if (RrMode) begin
      order[0] = ptr; order[1] = (ptr + 1) % 3; order[2] = (ptr + 2) % 3;
    end else begin
      order[0] = 1; order[1] = 0; order[2] = 2;
    end
    for (int k = 0; k < 3; k++) if (r[order[k]]) return order[k];
    return -1;
  endfunction

  typedef struct {
    string       name;
    int          who;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_off;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, off, nwe, spur, m_at;
    logic got;
    logic [15:0] rd, wa, wd;
    logic [2:0] gseen, gack, acks, oh;

    vecs[0] = '{"if_rd_3000",  0, 1'b0, 16'h3000, 16'h0000, 2 + LAT, 16'h1234};
    vecs[1] = '{"dm_st_4000",  1, 1'b1, 16'h4000, 16'hBEEF, 2,       16'h1234};
    vecs[2] = '{"dm_ld_4000",  1, 1'b0, 16'h4000, 16'h0000, 2 + LAT, 16'hBEEF};
    vecs[3] = '{"dbg_st_5000", 2, 1'b1, 16'h5000, 16'hCAFE, 2,       16'hBEEF};
    vecs[4] = '{"dbg_ld_5000", 2, 1'b0, 16'h5000, 16'h0000, 2 + LAT, 16'hCAFE};
    vecs[5] = '{"if_rd_4000",  0, 1'b0, 16'h4000, 16'h0000, 2 + LAT, 16'hBEEF};

    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i * 257) ^ 16'h5A5A;
      mm[i]  = 16'(i * 257) ^ 16'h5A5A;
    end
    mem[8'h30] = 16'h1234;

    clear_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset grant", 32'(grant), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset acks", 32'({dbg_ack, dm_ack, if_ack}), 32'h0);
    check("reset mem_we", 32'(mem_we), 32'h0);
    check("reset mem_addr", 32'(mem_addr), 32'h0);
    check("reset mem_wdata", 32'(mem_wdata), 32'h0);
    check("reset rdata", 32'(rdata), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed single transactions.
    foreach (vecs[i]) begin
      oh = 3'(1 << vecs[i].who);
      @(posedge clk); #1;
      set_req(vecs[i].who, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      c = cyc; got = 1'b0; nwe = 0; spur = 0; gseen = '0; gack = '0; off = -1;
      rd = '0; wa = '0; wd = '0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (mem_we) begin nwe++; wa = mem_addr; wd = mem_wdata; end
        if (gseen == 0 && grant != 0) gseen = grant;
        acks = {dbg_ack, dm_ack, if_ack};
        if ((acks & oh) != 0) begin
          got = 1'b1; off = cyc - c; rd = rdata; gack = grant;
          if (acks != oh) spur++;
        end else if (acks != 0) spur++;
      end
      check({vecs[i].name, " ack_seen"}, 32'(got), 32'h1);
      check({vecs[i].name, " latency"}, 32'(off), 32'(vecs[i].exp_off));
      check({vecs[i].name, " rdata"}, 32'(rd), 32'(vecs[i].exp_rdata));
      check({vecs[i].name, " grant"}, 32'(gseen), 32'(oh));
      check({vecs[i].name, " grant_at_ack"}, 32'(gack), 32'(oh));
      check({vecs[i].name, " other_acks"}, 32'(spur), 32'h0);
      check({vecs[i].name, " we_pulses"}, 32'(nwe), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check({vecs[i].name, " mem_addr"}, 32'(wa), 32'(vecs[i].addr));
        check({vecs[i].name, " mem_wdata"}, 32'(wd), 32'(vecs[i].wdata));
      end
      @(posedge clk); #1;
      set_req(vecs[i].who, 1'b0, 1'b0, 16'h0, 16'h0);
    end

    // Simultaneous dm load and if read.
    begin
      int if_at, dm_at, n_if, n_dm;
      logic [15:0] if_rd, dm_rd;
      do_reset();
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 16'h3000, 16'h0);
      set_req(1, 1'b1, 1'b0, 16'h4000, 16'h0);
      c = cyc; if_at = -1; dm_at = -1; n_if = 0; n_dm = 0; if_rd = '0; dm_rd = '0;
      for (int k = 0; k < 2 * (2 + LAT) + 6; k++) begin
        @(negedge clk);
        if (if_ack) begin n_if++; if_at = cyc - c; if_rd = rdata; end
        if (dm_ack) begin n_dm++; dm_at = cyc - c; dm_rd = rdata; end
        @(posedge clk); #1;
        if (n_if > 0) if_req = 1'b0;
        if (n_dm > 0) dm_req = 1'b0;
      end
      check("simul dm_ack_count", 32'(n_dm), 32'h1);
      check("simul if_ack_count", 32'(n_if), 32'h1);
      check("simul dm_latency", 32'(dm_at), 32'(RrMode ? 5 + 2 * LAT : 2 + LAT));
      check("simul if_latency", 32'(if_at), 32'(RrMode ? 2 + LAT : 5 + 2 * LAT));
      check("simul dm_rdata", 32'(dm_rd), 32'hBEEF);
      check("simul if_rdata", 32'(if_rd), 32'h1234);
    end

    // All three requesting continuously: grant order over six transactions.
    begin
      logic [2:0] order[6];
      logic [2:0] exp_order[6];
      int n;
      exp_order = RrMode ? '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100}
                         : '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
      do_reset();
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 16'h3000, 16'h0);
      set_req(1, 1'b1, 1'b0, 16'h4000, 16'h0);
      set_req(2, 1'b1, 1'b0, 16'h5000, 16'h0);
      n = 0;
      for (int k = 0; k < 6 * (3 + LAT) + 10 && n < 6; k++) begin
        @(negedge clk);
        if ({dbg_ack, dm_ack, if_ack} != 0) begin
          order[n] = grant;
          n++;
        end
      end
      check("order txn_count", 32'(n), 32'h6);
      for (int i = 0; i < 6; i++) if (i < n) check($sformatf("order grant%0d", i),
                                                   32'(order[i]), 32'(exp_order[i]));
      @(posedge clk); #1;
      clear_inputs();
    end

    // Reset asserted during WAIT of a read, then the held request restarts.
    begin
      int rst_acks, n_ack;
      do_reset();
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 16'h3000, 16'h0);
      c = cyc;
      repeat (3) @(negedge clk);  // cycles c, c+1, c+2 (c+2 is in WAIT)
      check("rstmid busy_before", 32'(busy), 32'h1);
      rst = 1'b0;
      #1;
      check("rstmid busy", 32'(busy), 32'h0);
      check("rstmid grant", 32'(grant), 32'h0);
      check("rstmid mem_we", 32'(mem_we), 32'h0);
      check("rstmid acks", 32'({dbg_ack, dm_ack, if_ack}), 32'h0);
      rst_acks = 0;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        if ({dbg_ack, dm_ack, if_ack} != 0) rst_acks++;
      end
      rst = 1'b1;
      m_at = cyc; off = -1; n_ack = 0; rd = '0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (if_ack) begin n_ack++; if (off < 0) begin off = cyc - m_at; rd = rdata; end end
        if (n_ack > 0) begin @(posedge clk); #1; if_req = 1'b0; end
      end
      check("rstmid acks_in_reset", 32'(rst_acks), 32'h0);
      check("rstmid restart_latency", 32'(off), 32'(2 + LAT));
      check("rstmid restart_rdata", 32'(rd), 32'h1234);
      check("rstmid restart_ack_count", 32'(n_ack), 32'h1);
    end

    // dbg drops req (and changes address) one cycle after grant.
    begin
      int n_ack;
      do_reset();
      @(posedge clk); #1;
      set_req(2, 1'b1, 1'b0, 16'h5000, 16'h0);
      c = cyc; n_ack = 0; off = -1; gseen = '0; rd = '0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (cyc == c + 1) gseen = grant;
        if (dbg_ack) begin n_ack++; off = cyc - c; rd = rdata; end
        @(posedge clk); #1;
        if (cyc == c + 2) set_req(2, 1'b0, 1'b0, 16'h3000, 16'h0);
      end
      check("dbgdrop grant", 32'(gseen), 32'h4);
      check("dbgdrop ack_count", 32'(n_ack), 32'h1);
      check("dbgdrop latency", 32'(off), 32'(2 + LAT));
      check("dbgdrop rdata", 32'(rd), 32'hCAFE);
    end

    // Random traffic against a transaction-level model.
    begin
      logic        r_req[3], r_we[3], acked[3];
      logic [15:0] r_addr[3], r_wdata[3];
      int          m_owner, m_issue, m_ack, m_ptr, t, w;
      logic        m_we, e_busy, e_we;
      logic [15:0] m_addr, m_wdata, m_last, e_rd;
      logic [2:0]  e_grant, e_acks;
      do_reset();
      m_owner = 0; m_issue = -1; m_ack = -1; m_ptr = 0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_last = '0;
      for (int i = 0; i < 3; i++) begin
        r_req[i] = 1'b0; r_we[i] = 1'b0; acked[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
      end
      for (int s = 0; s < 3000; s++) begin
        @(posedge clk); #1;
        t = cyc;
        for (int i = 0; i < 3; i++) begin
          if (acked[i] || (!r_req[i] && $urandom_range(0, 2) == 0)) begin
            r_req[i]   = acked[i] ? 1'($urandom_range(0, 1)) : 1'b1;
            r_we[i]    = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            r_addr[i]  = {4'($urandom_range(0, 7)), 8'h00, 4'h1};
            r_wdata[i] = 16'($urandom);
            acked[i]   = 1'b0;
          end
          set_req(i, r_req[i], r_we[i], r_addr[i], r_wdata[i]);
        end
        @(negedge clk);
        e_busy  = (t >= m_issue) && (t <= m_ack);
        e_grant = e_busy ? 3'(1 << m_owner) : 3'b000;
        e_acks  = (t == m_ack) ? 3'(1 << m_owner) : 3'b000;
        e_we    = m_we && (t == m_issue);
        check("rand grant", 32'(grant), 32'(e_grant));
        check("rand busy", 32'(busy), 32'(e_busy));
        check("rand acks", 32'({dbg_ack, dm_ack, if_ack}), 32'(e_acks));
        check("rand mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) begin
          check("rand mem_addr", 32'(mem_addr), 32'(m_addr));
          check("rand mem_wdata", 32'(mem_wdata), 32'(m_wdata));
          mm[hidx(m_addr)] = m_wdata;
        end
        if (t == m_ack) begin
          e_rd = m_we ? m_last : mm[hidx(m_addr)];
          check("rand rdata", 32'(rdata), 32'(e_rd));
          m_last = e_rd;
          acked[m_owner] = 1'b1;
        end
        if (t > m_ack) begin
          w = pick({r_req[2], r_req[1], r_req[0]}, m_ptr);
          if (w >= 0) begin
            m_owner = w; m_we = r_we[w]; m_addr = r_addr[w]; m_wdata = r_wdata[w];
            m_issue = t + 1;
            m_ack   = t + 2 + (m_we ? 0 : int'(LAT));
            m_ptr   = (w + 1) % 3;
          end
        end
      end
      @(posedge clk); #1;
      clear_inputs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
